logic_gate_pipe: RTL and testbench
==================================

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..64.
REQ-002 Parameter CNT_W, default 16, width of the transfer counter; legal range 4..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in1  input  WIDTH  operand A.
REQ-006 in2  input  WIDTH  operand B.
REQ-007 op  input  3  operation select, sampled with the operands.
REQ-008 in_valid  input  1  operand set present.
REQ-009 in_ready  output  1  block can accept an operand set.
REQ-010 out  output  WIDTH  result at buffer head.
REQ-011 out_all  output  1  AND-reduction of out.
REQ-012 out_valid  output  1  result present at buffer head.
REQ-013 out_ready  input  1  consumer accepts the head result.
REQ-014 xfer_count  output  CNT_W  number of results consumed.

Function
REQ-015 op encoding SHALL be bitwise per lane: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT in1 (in2 ignored), 111 pass in1.
REQ-016 An operand set SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; the result SHALL be computed from in1, in2 and op at that edge and written into a 2-entry FIFO.
REQ-017 Latency SHALL be 1 cycle: a result accepted into an empty FIFO SHALL set out_valid=1 after the same edge.
REQ-018 A result SHALL be consumed on a rising edge with out_valid=1 and out_ready=1.
REQ-019 The FIFO SHALL have states EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
REQ-020 EMPTY SHALL go to ONE on push only.
REQ-021 ONE SHALL go to FULL on push only, to EMPTY on pop only, and stay ONE on simultaneous push and pop.
REQ-022 FULL SHALL go to ONE on pop only; push cannot occur in FULL.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-024 out_valid SHALL be 1 exactly when the state is ONE or FULL.
REQ-025 Results SHALL leave in acceptance order; the order SHALL be preserved across pointer wrap.
REQ-026 out and out_all SHALL be driven from registered storage only, with no combinational path from inputs.
REQ-027 While out_valid=1 and out_ready=0, out, out_all and out_valid SHALL hold stable.
REQ-028 When out_valid=0, out SHALL hold its last value, or 0 after reset.
REQ-029 in1, in2 and op SHALL be ignored when no push occurs; in_valid with in_ready=0 SHALL NOT corrupt stored data.
REQ-030 xfer_count SHALL increment by 1 on every pop and SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-031 No result SHALL be dropped or duplicated under any interleaving of in_valid and out_ready.

Reset
REQ-032 Asserting rst SHALL immediately and asynchronously force the state to EMPTY, out=0, out_all=0, out_valid=0 and xfer_count=0.
REQ-033 in_ready SHALL be 0 while rst=1 and SHALL become 1 on the first clk edge after rst deasserts.
REQ-034 Reset asserted mid-operation SHALL discard all buffered results; no pop SHALL be counted for them.
REQ-035 Operand sets presented while rst=1 SHALL be discarded.

Verification
REQ-036 Run the bench with WIDTH=4. Sweep op=011 (NOR) through in1/in2 = 0000/0000, 0000/1111, 1111/0000, 1111/1111 with out_ready=1 -> out = 1111, 0000, 0000, 0000 and out_all = 1, 0, 0, 0, each 1 cycle after acceptance, with xfer_count=4 at the end.
REQ-037 Present all 8 ops with in1=1100, in2=1010 -> out = 1000, 1110, 0111, 0001, 0110, 1001, 0011, 1100, in that order.
REQ-038 Hold out_ready=0 and drive 3 consecutive valid sets -> in_ready falls to 0 after 2 accepts and the third set is held upstream. Then raise out_ready -> all 3 results are delivered in order and xfer_count=3.
REQ-039 Keep in_valid=1 and out_ready=1 continuously for 20 cycles -> 1 result per cycle after the first, with the FIFO staying in ONE.
REQ-040 With the FIFO FULL, assert rst between clock edges -> out_valid=0 and xfer_count=0 immediately; after release, the first new result emerges with no stale data.
REQ-041 Run with CNT_W=4 and consume 17 results -> xfer_count wraps 15 -> 0 and ends at 1.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: per-lane bitwise logic unit feeding a 2-entry result FIFO.
// The head result is kept in its own register so that out/out_all are driven
// straight from flops and hold their last value once the FIFO drains.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_all,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mem_r [2];
  logic             rd_ptr_r;
  logic             wr_ptr_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             out_all_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] head_nxt_s;
  logic             push_s;
  logic             pop_s;

  // Bitwise operation selected by op; in2 is unused for the unary encodings.
  function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0]       o);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a & b);
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign res_s  = calc(in1, in2, op);
  // in_ready is a flop, so the push decision never looks at out_ready.
  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Next FIFO occupancy and the value the head register should carry next.
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = out_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = res_s;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = res_s;
        end else if (push_s) begin
          state_nxt_s = FULL;
        end else if (pop_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = mem_r[~rd_ptr_r];
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        head_nxt_s  = out_r;
      end
    endcase
  end

  // Occupancy state, handshake flags and the registered head/outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      out_all_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
      out_r       <= head_nxt_s;
      out_all_r   <= &head_nxt_s;
    end
  end

  // Result storage and its 1-bit read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= res_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Count of consumed results; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (pop_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out        = out_r;
  assign out_all    = out_all_r;
  assign out_valid  = out_valid_r;
  assign xfer_count = cnt_r;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe (WIDTH=4, CNT_W=4).
module tb_logic_gate_pipe;

  logic       clk;
  logic       rst;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out;
  logic       out_all;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] xfer_count;

  int         n_cmp;
  int         n_fail;
  logic [3:0] sb[$];
  logic [3:0] got[$];
  int         exp_cnt;
  logic [3:0] last_exp;
  logic       skip_ready;
  logic [3:0] tt_tab[8];
  logic [3:0] lst[8];
  logic       lst_all[4];

  logic_gate_pipe #(.WIDTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_all(out_all),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truth table per op, indexed by {a_bit, b_bit}.
  function automatic logic [3:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    logic [3:0] t;
    logic [3:0] r;
    t = tt_tab[o];
    for (int i = 0; i < 4; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record accepted operand sets (inputs are stable between edges).
  always @(negedge clk) begin
    #1;
    if (!rst && in_valid && in_ready) sb.push_back(ref_res(in1, in2, op));
  end

  // Monitor: compare DUT head against scoreboard before each edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, sb.size() != 0);
      if (!skip_ready) chk("in_ready", in_ready, sb.size() < 2);
      chk("xfer_count", xfer_count, exp_cnt[3:0]);
      if (sb.size() == 0) chk("out_hold", out, last_exp);
      if (out_valid && sb.size() > 0) begin
        chk("out", out, sb[0]);
        chk("out_all", out_all, &sb[0]);
        if (out_ready) begin
          last_exp = sb.pop_front();
          got.push_back(out);
          exp_cnt = (exp_cnt + 1) % 16;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in1 = 4'($urandom);
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
    last_exp = 4'b0000;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_xfer", xfer_count, 4'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out", out, 4'b0000);
    chk("rst_out_all", out_all, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    skip_ready = 1'b1;
    chk("rel_in_ready0", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rel_in_ready1", in_ready, 1'b1);
    skip_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
    in1 = a; in2 = b; op = o; in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) step();
    if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
    step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && (sb.size() != 0 || out_valid); k++) step();
    chk("drain_done", (sb.size() == 0) && !out_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; exp_cnt = 0; last_exp = 4'b0000; skip_ready = 1'b1;
    tt_tab[0] = 4'b1000; tt_tab[1] = 4'b1110; tt_tab[2] = 4'b0111; tt_tab[3] = 4'b0001;
    tt_tab[4] = 4'b0110; tt_tab[5] = 4'b1001; tt_tab[6] = 4'b0011; tt_tab[7] = 4'b1100;
    rst = 1'b1; in1 = 4'b0000; in2 = 4'b0000; op = 3'b000; in_valid = 1'b0; out_ready = 1'b0;

    // NOR sweep
    do_reset();
    got.delete();
    out_ready = 1'b1;
    send(4'b0000, 4'b0000, 3'b011);
    send(4'b0000, 4'b1111, 3'b011);
    send(4'b1111, 4'b0000, 3'b011);
    send(4'b1111, 4'b1111, 3'b011);
    drain();
    lst[0] = 4'b1111; lst[1] = 4'b0000; lst[2] = 4'b0000; lst[3] = 4'b0000;
    lst_all[0] = 1'b1; lst_all[1] = 1'b0; lst_all[2] = 1'b0; lst_all[3] = 1'b0;
    chk("nor_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("nor_out", got[i], lst[i]);
      chk("nor_all", &got[i], lst_all[i]);
    end
    chk("nor_xfer", xfer_count, 4'd4);

    // All eight ops on 1100/1010
    do_reset();
    got.delete();
    out_ready = 1'b1;
    for (int o = 0; o < 8; o++) send(4'b1100, 4'b1010, 3'(o));
    drain();
    lst[0] = 4'b1000; lst[1] = 4'b1110; lst[2] = 4'b0111; lst[3] = 4'b0001;
    lst[4] = 4'b0110; lst[5] = 4'b1001; lst[6] = 4'b0011; lst[7] = 4'b1100;
    chk("ops_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("ops_out", got[i], lst[i]);

    // Backpressure: fill, hold third set upstream, then release
    do_reset();
    got.delete();
    out_ready = 1'b0;
    send(4'b1100, 4'b1010, 3'b000);
    send(4'b1100, 4'b1010, 3'b001);
    chk("full_in_ready", in_ready, 1'b0);
    in1 = 4'b1100; in2 = 4'b1010; op = 3'b100; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_in_ready", in_ready, 1'b0);
      chk("held_out", out, 4'b1000);
    end
    out_ready = 1'b1;
    send(4'b1100, 4'b1010, 3'b100);
    drain();
    chk("bp_count", got.size(), 3);
    lst[0] = 4'b1000; lst[1] = 4'b1110; lst[2] = 4'b0110;
    for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_out", got[i], lst[i]);
    chk("bp_xfer", xfer_count, 4'd3);

    // Streaming: 20 cycles of continuous push and pop
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in1 = 4'($urandom); in2 = 4'($urandom); op = 3'($urandom);
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_ready", in_ready, 1'b1);
    end
    drain();
    chk("stream_xfer", xfer_count, 4'd4);

    // Reset while FULL, then a fresh result
    do_reset();
    out_ready = 1'b1;
    send(4'b0101, 4'b0011, 3'b100);
    drain();
    out_ready = 1'b0;
    send(4'b1111, 4'b1111, 3'b000);
    send(4'b0000, 4'b0000, 3'b011);
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 1'b0);
    do_reset();
    got.delete();
    out_ready = 1'b1;
    send(4'b1010, 4'b0110, 3'b001);
    drain();
    chk("post_rst_count", got.size(), 1);
    if (got.size() > 0) chk("post_rst_out", got[0], 4'b1110);
    chk("post_rst_xfer", xfer_count, 4'd1);

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(4'($urandom), 4'($urandom), 3'($urandom));
    drain();
    chk("wrap_15", xfer_count, 4'd15);
    send(4'b0001, 4'b0010, 3'b001);
    drain();
    chk("wrap_0", xfer_count, 4'd0);
    send(4'b0001, 4'b0010, 3'b001);
    drain();
    chk("wrap_1", xfer_count, 4'd1);

    // Random interleaving
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in1 = 4'($urandom); in2 = 4'($urandom); op = 3'($urandom);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
